instr_encoder: RTL and testbench

Sequential MIPS instruction encoder and program loader: the inverse of the control decoder. Accepts one symbolic instruction per handshake (operation class plus register/immediate fields), packs it into a 32-bit MIPS word, and writes it to consecutive instruction-memory word addresses. Used by the testbench/boot path to build programs that the single-cycle core then fetches and decodes.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/instr_pack.sv | 54 +++++
 rtl/instr_encoder.sv | 154 +++++++++++++++
 tb/tb_instr_encoder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS encoding constants: 4-bit symbolic operation
//               enumeration, primary opcodes and R-type funct codes. The
//               control decoder uses the same opcode and funct values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  // Symbolic operation classes presented to the encoder
  typedef enum logic [3:0] {
    ENC_ADD  = 4'd0,
    ENC_SUB  = 4'd1,
    ENC_AND  = 4'd2,
    ENC_OR   = 4'd3,
    ENC_SLT  = 4'd4,
    ENC_SLL  = 4'd5,
    ENC_SRL  = 4'd6,
    ENC_JR   = 4'd7,
    ENC_ADDI = 4'd8,
    ENC_LW   = 4'd9,
    ENC_SW   = 4'd10,
    ENC_BEQ  = 4'd11,
    ENC_BNE  = 4'd12,
    ENC_J    = 4'd13,
    ENC_JAL  = 4'd14,
    ENC_RSVD = 4'd15
  } enc_op_e;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // R-type function codes (instruction bits [5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

endpackage

`default_nettype wire

// File: rtl/instr_pack.sv
// ============================================================================
// Module      : instr_pack
// Description : Combinational field packer. Turns a symbolic operation plus
//               register/immediate fields into a 32-bit MIPS word and flags
//               the reserved operation code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [25:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  // Select opcode/funct and mask the fields each format does not use
  always_comb begin
    o_word    = 32'h0000_0000;
    o_illegal = 1'b0;
    case (i_op)
      ENC_ADD:  o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_ADD};
      ENC_SUB:  o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_SUB};
      ENC_AND:  o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_AND};
      ENC_OR:   o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_OR};
      ENC_SLT:  o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_SLT};
      ENC_SLL:  o_word = {OP_RTYPE, i_rs, i_rt, i_rd, i_shamt, FN_SLL};
      ENC_SRL:  o_word = {OP_RTYPE, i_rs, i_rt, i_rd, i_shamt, FN_SRL};
      // JR carries only rs; rt, rd and shamt are zero in the encoding
      ENC_JR:   o_word = {OP_RTYPE, i_rs, 15'd0, FN_JR};
      ENC_ADDI: o_word = {OP_ADDI, i_rs, i_rt, i_imm[15:0]};
      ENC_LW:   o_word = {OP_LW,   i_rs, i_rt, i_imm[15:0]};
      ENC_SW:   o_word = {OP_SW,   i_rs, i_rt, i_imm[15:0]};
      ENC_BEQ:  o_word = {OP_BEQ,  i_rs, i_rt, i_imm[15:0]};
      ENC_BNE:  o_word = {OP_BNE,  i_rs, i_rt, i_imm[15:0]};
      ENC_J:    o_word = {OP_J,    i_imm};
      ENC_JAL:  o_word = {OP_JAL,  i_imm};
      // Reserved code packs as the all-zero NOP word
      default: begin
        o_word    = 32'h0000_0000;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Sequential MIPS instruction encoder / program loader. Accepts
//               one symbolic instruction per handshake, packs it and writes it
//               to consecutive instruction-memory word addresses.
//               Optional macro ENC_ERR_EN adds a sticky err output that
//               rejects the reserved operation instead of writing a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
`ifdef ENC_ERR_EN
  output logic              err,
`endif
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] c_BASE_PTR = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] c_LAST_PTR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_wdata;
  logic              r_last;
  logic              r_full;
  logic [31:0]       w_word;
`ifdef ENC_ERR_EN
  logic              w_illegal;
  logic              r_err;
`else
  logic              w_illegal_unused;
`endif

  instr_pack u_pack (
    .i_op      (in_op),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_shamt   (in_shamt),
    .i_imm     (in_imm),
    .o_word    (w_word),
`ifdef ENC_ERR_EN
    .o_illegal (w_illegal)
`else
    .o_illegal (w_illegal_unused)
`endif
  );

  // Session FSM with pointer, count and handshake register; start overrides all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= c_BASE_PTR;
      r_count <= '0;
      r_wdata <= 32'h0000_0000;
      r_last  <= 1'b0;
      r_full  <= 1'b0;
`ifdef ENC_ERR_EN
      r_err   <= 1'b0;
`endif
    end else if (start) begin
      r_state <= S_ACCEPT;
      r_ptr   <= c_BASE_PTR;
      r_count <= '0;
      r_full  <= 1'b0;
`ifdef ENC_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_ACCEPT: begin
          if (in_valid) begin
`ifdef ENC_ERR_EN
            if (w_illegal) begin
              // Rejected instruction: nothing written, pointer/count kept
              r_err   <= 1'b1;
              r_state <= in_last ? S_DONE : S_ACCEPT;
            end else begin
              r_wdata <= w_word;
              r_last  <= in_last;
              r_state <= S_WRITE;
            end
`else
            r_wdata <= w_word;
            r_last  <= in_last;
            r_state <= S_WRITE;
`endif
          end
        end
        S_WRITE: begin
          r_ptr   <= r_ptr + 1'b1;
          r_count <= r_count + 1'b1;
          if (r_ptr == c_LAST_PTR) begin
            r_full <= 1'b1;
          end
          if (r_last || (r_ptr == c_LAST_PTR)) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_ACCEPT;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Outputs decode the registered state; start suppresses a pending write
  assign in_ready  = (r_state == S_ACCEPT);
  assign mem_wen   = (r_state == S_WRITE) && !start;
  assign mem_addr  = r_ptr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state == S_ACCEPT) || (r_state == S_WRITE);
  assign done      = (r_state == S_DONE);
  assign full      = r_full;
  assign count     = r_count;
`ifdef ENC_ERR_EN
  assign err       = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed self-checking bench for instr_encoder. A default
//               instance (ADDR_W=10) covers encoding and control; a second
//               instance with ADDR_W=2 covers the memory-full boundary.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        start, start2;
  logic        in_valid, in_valid2;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [25:0] in_imm;
  logic        in_last;

  logic        in_ready, mem_wen, busy, done, full;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] count;

  logic        in_ready2, mem_wen2, busy2, done2, full2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  count2;
`ifdef ENC_ERR_EN
  logic        err, err2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm), .in_last(in_last),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .full(full),
`ifdef ENC_ERR_EN
    .err(err),
`endif
    .count(count)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2),
    .in_ready(in_ready2), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm), .in_last(in_last),
    .mem_wen(mem_wen2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .busy(busy2), .done(done2), .full(full2),
`ifdef ENC_ERR_EN
    .err(err2),
`endif
    .count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed encoding vectors: SLL, JR (rd/shamt masked), BNE, JAL
  logic [3:0]  t_op  [4] = '{4'd5, 4'd7, 4'd12, 4'd14};
  logic [4:0]  t_rs  [4] = '{5'd0, 5'd31, 5'd4, 5'd0};
  logic [4:0]  t_rt  [4] = '{5'd1, 5'd0, 5'd0, 5'd0};
  logic [4:0]  t_rd  [4] = '{5'd2, 5'd5, 5'd0, 5'd0};
  logic [4:0]  t_sh  [4] = '{5'd3, 5'd7, 5'd0, 5'd0};
  logic [25:0] t_imm [4] = '{26'd0, 26'd0, 26'h000FFFF, 26'h0000010};
  logic [31:0] t_exp [4] = '{32'h000110C0, 32'h03E00008, 32'h1480FFFF, 32'h0C000010};

  // Pulse start on the selected instance; returns one cycle later in ACCEPT
  task automatic do_start(input bit sel);
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  // Present one instruction and complete the handshake; ends in the cycle after it
  task automatic send(input bit sel, input logic [3:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                      input logic [25:0] imm, input logic last, output bit ok);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_last = last;
    if (sel) in_valid2 = 1'b1; else in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (sel ? in_ready2 : in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_valid2 = 1'b0;
    in_op = 4'hA; in_rs = 5'h1F; in_rt = 5'h1F; in_rd = 5'h1F; in_imm = '1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({in_ready, mem_wen, busy, done, full} !== 5'b0 || count !== 11'd0 ||
        mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b wen=%b busy=%b done=%b full=%b cnt=%0d addr=%0d data=%h exp all 0",
               in_ready, mem_wen, busy, done, full, count, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start got rdy=%b busy=%b exp 0 0", in_ready, busy);
    end
  endtask

  task automatic test_addi_single();
    bit ok;
    do_start(1'b0);
    send(1'b0, 4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 26'h0000005, 1'b1, ok);
    n_tests++;
    if (!ok || mem_wen !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'h20220005) begin
      n_fail++;
      $display("FAIL addi_write got ok=%b wen=%b addr=%0d data=%h exp 1 1 0 20220005",
               ok, mem_wen, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b1 || count !== 11'd1 || in_ready !== 1'b0 || mem_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_done got done=%b cnt=%0d rdy=%b wen=%b exp 1 1 0 0",
               done, count, in_ready, mem_wen);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_start(1'b0);
    send(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b0, ok);
    n_tests++;
    if (!ok || mem_wen !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'h00221820) begin
      n_fail++;
      $display("FAIL add_write got ok=%b wen=%b addr=%0d data=%h exp 1 1 0 00221820",
               ok, mem_wen, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    n_tests++;
    if (mem_wen !== 1'b0 || in_ready !== 1'b1 || count !== 11'd1) begin
      n_fail++;
      $display("FAIL gap_cycle got wen=%b rdy=%b cnt=%0d exp 0 1 1", mem_wen, in_ready, count);
    end
    send(1'b0, 4'd9, 5'd29, 5'd8, 5'd0, 5'd0, 26'h0000004, 1'b1, ok);
    n_tests++;
    if (!ok || mem_wen !== 1'b1 || mem_addr !== 10'd1 || mem_wdata !== 32'h8FA80004) begin
      n_fail++;
      $display("FAIL lw_write got ok=%b wen=%b addr=%0d data=%h exp 1 1 1 8FA80004",
               ok, mem_wen, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b1 || count !== 11'd2 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL two_done got done=%b cnt=%0d full=%b exp 1 2 0", done, count, full);
    end
  endtask

  task automatic test_encodings();
    bit ok;
    do_start(1'b0);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, t_op[i], t_rs[i], t_rt[i], t_rd[i], t_sh[i], t_imm[i], (i == 3), ok);
      n_tests++;
      if (!ok || mem_wen !== 1'b1 || mem_addr !== 10'(i) || mem_wdata !== t_exp[i]) begin
        n_fail++;
        $display("FAIL encode_%0d got ok=%b wen=%b addr=%0d data=%h exp addr=%0d data=%h",
                 i, ok, mem_wen, mem_addr, mem_wdata, i, t_exp[i]);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (done !== 1'b1 || count !== 11'd4) begin
      n_fail++;
      $display("FAIL encode_done got done=%b cnt=%0d exp 1 4", done, count);
    end
  endtask

  task automatic test_start_in_write();
    bit ok;
    do_start(1'b0);
    send(1'b0, 4'd1, 5'd3, 5'd4, 5'd5, 5'd0, 26'd0, 1'b0, ok);
    start = 1'b1;
    #1;
    n_tests++;
    if (!ok || mem_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL start_suppress got ok=%b wen=%b exp 1 0", ok, mem_wen);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (count !== 11'd0 || in_ready !== 1'b1 || done !== 1'b0 || mem_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL start_restart got cnt=%0d rdy=%b done=%b addr=%0d exp 0 1 0 0",
               count, in_ready, done, mem_addr);
    end
    send(1'b0, 4'd10, 5'd2, 5'd3, 5'd0, 5'd0, 26'h3FF0008, 1'b1, ok);
    n_tests++;
    if (!ok || mem_wen !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'hAC430008) begin
      n_fail++;
      $display("FAIL restart_write got ok=%b wen=%b addr=%0d data=%h exp 1 1 0 AC430008",
               ok, mem_wen, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reserved_op();
    bit ok;
    do_start(1'b0);
`ifdef ENC_ERR_EN
    send(1'b0, 4'd15, 5'd1, 5'd1, 5'd1, 5'd1, 26'h1, 1'b0, ok);
    n_tests++;
    if (!ok || mem_wen !== 1'b0 || err !== 1'b1 || count !== 11'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reserved_err got ok=%b wen=%b err=%b cnt=%0d rdy=%b exp 1 0 1 0 1",
               ok, mem_wen, err, count, in_ready);
    end
    do_start(1'b0);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got err=%b exp 0", err);
    end
`else
    send(1'b0, 4'd15, 5'd1, 5'd1, 5'd1, 5'd1, 26'h1, 1'b1, ok);
    n_tests++;
    if (!ok || mem_wen !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'h00000000) begin
      n_fail++;
      $display("FAIL reserved_nop got ok=%b wen=%b addr=%0d data=%h exp 1 1 0 00000000",
               ok, mem_wen, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    n_tests++;
    if (count !== 11'd1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL reserved_count got cnt=%0d done=%b exp 1 1", count, done);
    end
`endif
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_start(1'b0);
    send(1'b0, 4'd3, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b0, ok);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (!ok || mem_wen !== 1'b0 || busy !== 1'b0 || count !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_reset got ok=%b wen=%b busy=%b cnt=%0d exp 1 0 0 0",
               ok, mem_wen, busy, count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    bit ok;
    do_start(1'b1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 4'd0, 5'd1, 5'd2, 5'(i), 5'd0, 26'd0, 1'b0, ok);
      n_tests++;
      if (!ok || mem_wen2 !== 1'b1 || mem_addr2 !== 2'(i) ||
          mem_wdata2 !== (32'h00220020 | (32'(i) << 11))) begin
        n_fail++;
        $display("FAIL full_write_%0d got ok=%b wen=%b addr=%0d data=%h exp addr=%0d",
                 i, ok, mem_wen2, mem_addr2, mem_wdata2, i);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (full2 !== 1'b1 || done2 !== 1'b1 || count2 !== 3'd4 || in_ready2 !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flags got full=%b done=%b cnt=%0d rdy=%b exp 1 1 4 0",
               full2, done2, count2, in_ready2);
    end
    in_valid2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (in_ready2 !== 1'b0 || mem_wen2 !== 1'b0 || count2 !== 3'd4) begin
        n_fail++;
        $display("FAIL full_hold_%0d got rdy=%b wen=%b cnt=%0d exp 0 0 4",
                 i, in_ready2, mem_wen2, count2);
      end
    end
    in_valid2 = 1'b0;
  endtask

  initial begin
    start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0;
    in_imm = 26'd0; in_last = 1'b0;
    test_reset();
    test_addi_single();
    test_back_to_back();
    test_encodings();
    test_start_in_write();
    test_reserved_op();
    test_mid_reset();
    test_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
